// File: rtl/eth_pkt_pkg.sv
// -----------------------------------------------------------------------------
// eth_pkt_pkg
// Shared definitions for the Ethernet packet control path:
//   - state_t : FSM state encoding (also exported on state_o for debug)
//   - err_t   : error codes reported on err_code
//   - END_MARK_DEFAULT : data value that closes a frame when control is low
// -----------------------------------------------------------------------------
package eth_pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_TAIL    = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_ABORT       = 3'd1,
        ERR_HDR_TIMEOUT = 3'd2,
        ERR_OVERSIZE    = 3'd3,
        ERR_RUNT        = 3'd4
    } err_t;

    localparam int END_MARK_DEFAULT = 0;

endpackage

// File: rtl/eth_packet_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Beat counter that saturates at all-ones instead of wrapping.
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset, clears the count
//   clear  : restart the count; if inc is also high the new count is 1,
//            so a frame's first beat is counted in the same cycle
//   inc    : add one (ignored once the count is all-ones)
//   count  : current count, registered
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] L_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] L_SAT = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= inc ? L_ONE : '0;
        end else if (inc && (r_count != L_SAT)) begin
            r_count <= r_count + L_ONE;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/eth_packet_ctrl.sv
// -----------------------------------------------------------------------------
// eth_packet_ctrl
// Frame-level control for the Ethernet byte stream. Walks each frame through
// IDLE -> HEADER -> PAYLOAD -> TAIL (or ERROR), enables the header and payload
// parsers, counts header/payload beats and reports the frame outcome.
//
// Ports
//   clock              : rising-edge clock
//   reset              : asynchronous active-low reset
//   control            : frame-valid qualifier; a cycle with control=1 is a beat
//   data               : stream beat; END_MARK with control=0 closes a frame
//   type_length_valid  : header parser found the type/length field
//   packet_size_valid  : payload parser reached the declared size
//   enable_header      : header parser enable (Mealy, same cycle as control)
//   enable_payload     : payload parser enable (Mealy, same cycle as control)
//   byte_count         : payload beats of the current or last frame
//   packet_done        : one-cycle pulse, good frame ended
//   packet_error       : one-cycle pulse, frame rejected (code on err_code)
//   err_code           : err_t code, held until the next frame starts
//   state_o            : current FSM state for debug
// -----------------------------------------------------------------------------
module eth_packet_ctrl
    import eth_pkt_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int END_MARK    = END_MARK_DEFAULT,
    parameter int HDR_MAX     = 14,
    parameter int MIN_PAYLOAD = 46,
    parameter int MAX_PAYLOAD = 1500,
    parameter int CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              control,
    input  logic [DATA_W-1:0] data,
    input  logic              type_length_valid,
    input  logic              packet_size_valid,
    output logic              enable_header,
    output logic              enable_payload,
    output logic [CNT_W-1:0]  byte_count,
    output logic              packet_done,
    output logic              packet_error,
    output logic [2:0]        err_code,
    output logic [2:0]        state_o
);

    localparam logic [DATA_W-1:0] L_END_MARK = DATA_W'(END_MARK);
    // Limits are compared against the count *before* the current beat is
    // added, so "this beat is number N" becomes "count == N-1" (or above,
    // for the tail, which can be entered already at the limit).
    localparam logic [CNT_W-1:0]  L_HDR_LAST = CNT_W'(HDR_MAX - 1);
    localparam logic [CNT_W-1:0]  L_PAY_LAST = CNT_W'(MAX_PAYLOAD - 1);
    localparam logic [CNT_W-1:0]  L_PAY_MIN  = CNT_W'(MIN_PAYLOAD);

    state_t           r_state;
    err_t             r_err_code;
    logic             r_packet_done;
    logic             r_packet_error;
    logic [CNT_W-1:0] r_hdr_cnt;
    logic [CNT_W-1:0] r_pay_cnt;

    logic w_beat;
    logic w_end_mark;
    logic w_in_hdr;
    logic w_in_pay;
    logic w_frame_start;
    logic w_pay_inc;
    logic w_hdr_inc;

    // control is gated by reset so both enables drop the moment reset asserts.
    assign w_beat        = reset & control;
    assign w_end_mark    = !control && (data == L_END_MARK);
    assign w_in_hdr      = (r_state == ST_IDLE) || (r_state == ST_HEADER);
    assign w_in_pay      = (r_state == ST_PAYLOAD) || (r_state == ST_TAIL);
    assign w_frame_start = w_beat && (r_state == ST_IDLE);
    assign w_hdr_inc     = w_beat && w_in_hdr;
    assign w_pay_inc     = w_beat && w_in_pay;

    assign enable_header  = w_beat && w_in_hdr;
    assign enable_payload = w_beat && w_in_pay;

    // The IDLE beat is header beat 1: clear and inc together load 1.
    sat_counter #(.CNT_W(CNT_W)) u_hdr_cnt (
        .clock (clock),
        .reset (reset),
        .clear (w_frame_start),
        .inc   (w_hdr_inc),
        .count (r_hdr_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_pay_cnt (
        .clock (clock),
        .reset (reset),
        .clear (w_frame_start),
        .inc   (w_pay_inc),
        .count (r_pay_cnt)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_err_code     <= ERR_NONE;
            r_packet_done  <= 1'b0;
            r_packet_error <= 1'b0;
        end else begin
            r_packet_done  <= 1'b0;
            r_packet_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (control) begin
                        r_err_code <= ERR_NONE;
                        r_state    <= type_length_valid ? ST_PAYLOAD : ST_HEADER;
                    end
                end

                ST_HEADER: begin
                    // A found type/length wins even on the timeout beat.
                    if (type_length_valid) begin
                        r_state <= ST_PAYLOAD;
                    end else if (!control) begin
                        r_state        <= ST_ERROR;
                        r_err_code     <= ERR_ABORT;
                        r_packet_error <= 1'b1;
                    end else if (r_hdr_cnt >= L_HDR_LAST) begin
                        r_state        <= ST_ERROR;
                        r_err_code     <= ERR_HDR_TIMEOUT;
                        r_packet_error <= 1'b1;
                    end
                end

                ST_PAYLOAD: begin
                    if (packet_size_valid) begin
                        r_state <= ST_TAIL;
                    end else if (!control) begin
                        r_state        <= ST_ERROR;
                        r_err_code     <= ERR_ABORT;
                        r_packet_error <= 1'b1;
                    end else if (r_pay_cnt >= L_PAY_LAST) begin
                        r_state        <= ST_ERROR;
                        r_err_code     <= ERR_OVERSIZE;
                        r_packet_error <= 1'b1;
                    end
                end

                ST_TAIL: begin
                    if (control) begin
                        if (r_pay_cnt >= L_PAY_LAST) begin
                            r_state        <= ST_ERROR;
                            r_err_code     <= ERR_OVERSIZE;
                            r_packet_error <= 1'b1;
                        end
                    end else if (w_end_mark) begin
                        r_state <= ST_IDLE;
                        if (r_pay_cnt >= L_PAY_MIN) begin
                            r_packet_done <= 1'b1;
                        end else begin
                            r_err_code     <= ERR_RUNT;
                            r_packet_error <= 1'b1;
                        end
                    end
                end

                ST_ERROR: begin
                    // Drain the rest of the rejected frame silently.
                    if (w_end_mark) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign byte_count   = r_pay_cnt;
    assign packet_done  = r_packet_done;
    assign packet_error = r_packet_error;
    assign err_code     = r_err_code;
    assign state_o      = r_state;

endmodule

// File: tb/tb_eth_packet_ctrl.sv
// -----------------------------------------------------------------------------
// tb_eth_packet_ctrl
// Frame-level stimulus: each frame is described by its lengths (header beats,
// payload beats, tail beats) or by where it is cut short. The expected outcome
// of a frame is derived from those lengths alone and queued when the cycle
// that should trigger it is driven. A monitor pops the queue whenever the DUT
// pulses packet_done/packet_error and compares kind, code, count and cycle.
// -----------------------------------------------------------------------------
module tb_eth_packet_ctrl;
    import eth_pkt_pkg::*;

    localparam int         HDR_MAX     = 14;
    localparam int         MIN_PAYLOAD = 46;
    localparam int         MAX_PAYLOAD = 1500;
    localparam logic [7:0] END_MARK    = 8'h00;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        control = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        type_length_valid = 1'b0;
    logic        packet_size_valid = 1'b0;
    logic        enable_header;
    logic        enable_payload;
    logic [15:0] byte_count;
    logic        packet_done;
    logic        packet_error;
    logic [2:0]  err_code;
    logic [2:0]  state_o;

    eth_packet_ctrl #(
        .DATA_W      (8),
        .END_MARK    (0),
        .HDR_MAX     (HDR_MAX),
        .MIN_PAYLOAD (MIN_PAYLOAD),
        .MAX_PAYLOAD (MAX_PAYLOAD),
        .CNT_W       (16)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .control           (control),
        .data              (data),
        .type_length_valid (type_length_valid),
        .packet_size_valid (packet_size_valid),
        .enable_header     (enable_header),
        .enable_payload    (enable_payload),
        .byte_count        (byte_count),
        .packet_done       (packet_done),
        .packet_error      (packet_error),
        .err_code          (err_code),
        .state_o           (state_o)
    );

    always #5 clock = ~clock;

    longint cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit         is_done;
        logic [2:0] code;
        int         count;
        longint     due;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: outcome of a frame from its lengths.
    function automatic exp_t mk(input bit is_done, input logic [2:0] code, input int count);
        exp_t e;
        e.is_done = is_done;
        e.code    = code;
        e.count   = count;
        e.due     = 0;
        return e;
    endfunction

    function automatic exp_t model_closed_frame(input int pay_beats);
        if (pay_beats >= MIN_PAYLOAD) return mk(1'b1, ERR_NONE, pay_beats);
        else                          return mk(1'b0, ERR_RUNT, pay_beats);
    endfunction

    function automatic logic [7:0] rnd_data();
        return 8'($urandom);
    endfunction

    function automatic logic [7:0] rnd_nonend();
        logic [7:0] v;
        do v = 8'($urandom); while (v == END_MARK);
        return v;
    endfunction

    // One clock cycle of stimulus, driven just after the falling edge. The
    // expected enables for this cycle are checked once inputs have settled.
    task automatic cyc_drive(input logic c, input logic [7:0] d, input logic tl,
                             input logic ps, input logic eh, input logic ep,
                             input bit push, input exp_t e);
        exp_t ee;
        @(negedge clock);
        control           = c;
        data              = d;
        type_length_valid = tl;
        packet_size_valid = ps;
        if (push) begin
            ee     = e;
            ee.due = cyc + 1;
            sb_q.push_back(ee);
        end
        #1;
        check("enable_header", enable_header, eh);
        check("enable_payload", enable_payload, ep);
    endtask

    task automatic drv(input logic c, input logic [7:0] d, input logic tl,
                       input logic ps, input logic eh, input logic ep);
        cyc_drive(c, d, tl, ps, eh, ep, 1'b0, mk(1'b0, 3'd0, 0));
    endtask

    task automatic drv_push(input logic c, input logic [7:0] d, input logic eh,
                            input logic ep, input exp_t e);
        cyc_drive(c, d, 1'b0, 1'b0, eh, ep, 1'b1, e);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) drv(1'b0, rnd_data(), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_header(input int h, input bit tlv_last);
        for (int i = 1; i <= h; i++)
            drv(1'b1, rnd_data(), tlv_last && (i == h), 1'b0, 1'b1, 1'b0);
    endtask

    task automatic send_payload(input int p, input bit psv_last);
        for (int i = 1; i <= p; i++)
            drv(1'b1, rnd_data(), 1'b0, psv_last && (i == p), 1'b0, 1'b1);
    endtask

    // Rest of a rejected frame: random beats and idle cycles, then the marker.
    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 0)
                drv(1'b1, rnd_data(), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
            else
                drv(1'b0, rnd_nonend(), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        drv(1'b0, END_MARK, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame_closed(input int h, input int p, input int t);
        send_header(h, 1'b1);
        send_payload(p, 1'b1);
        for (int i = 0; i < t; i++) begin
            if ($urandom_range(0, 3) == 0) drv(1'b0, rnd_nonend(), 1'b0, 1'b0, 1'b0, 1'b0);
            drv(1'b1, rnd_data(), 1'b0, 1'b0, 1'b0, 1'b1);
        end
        drv_push(1'b0, END_MARK, 1'b0, 1'b0, model_closed_frame(p + t));
    endtask

    task automatic frame_hdr_timeout();
        send_header(HDR_MAX - 1, 1'b0);
        drv_push(1'b1, rnd_data(), 1'b1, 1'b0, mk(1'b0, ERR_HDR_TIMEOUT, 0));
        drain($urandom_range(1, 4));
    endtask

    task automatic frame_hdr_abort(input int k);
        send_header(k, 1'b0);
        drv_push(1'b0, rnd_data(), 1'b0, 1'b0, mk(1'b0, ERR_ABORT, 0));
        drain($urandom_range(0, 3));
    endtask

    task automatic frame_pay_abort(input int h, input int p);
        send_header(h, 1'b1);
        send_payload(p, 1'b0);
        drv_push(1'b0, rnd_data(), 1'b0, 1'b0, mk(1'b0, ERR_ABORT, p));
        drain($urandom_range(0, 3));
    endtask

    task automatic frame_oversize(input int h);
        send_header(h, 1'b1);
        send_payload(MAX_PAYLOAD - 1, 1'b0);
        drv_push(1'b1, rnd_data(), 1'b0, 1'b1, mk(1'b0, ERR_OVERSIZE, MAX_PAYLOAD));
        drain(2);
    endtask

    // Size reached exactly at the limit; one more tail beat is one too many.
    task automatic frame_tail_oversize(input int h);
        send_header(h, 1'b1);
        send_payload(MAX_PAYLOAD, 1'b1);
        drv_push(1'b1, rnd_data(), 1'b0, 1'b1, mk(1'b0, ERR_OVERSIZE, MAX_PAYLOAD + 1));
        drain(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, state_o, ST_IDLE);
        check({tag, "_byte_count"}, byte_count, 0);
        check({tag, "_err_code"}, err_code, ERR_NONE);
        check({tag, "_packet_done"}, packet_done, 0);
        check({tag, "_packet_error"}, packet_error, 0);
        check({tag, "_enable_header"}, enable_header, 0);
        check({tag, "_enable_payload"}, enable_payload, 0);
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        exp_t e;
        if (reset && (packet_done || packet_error)) begin
            check("pulse_exclusive", packet_done & packet_error, 0);
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", packet_done | packet_error, 0);
            end else begin
                e = sb_q.pop_front();
                check("pulse_kind_done", packet_done, e.is_done);
                check("pulse_err_code", err_code, e.code);
                check("pulse_byte_count", byte_count, e.count);
                check("pulse_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kind;
        // Reset held with control high: enables must stay gated off.
        control           = 1'b1;
        type_length_valid = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        check_reset_outputs("reset");
        control           = 1'b0;
        type_length_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        gap(2);

        // Good minimum frame: timeout beat carries type/length -> no timeout.
        frame_closed(HDR_MAX, MIN_PAYLOAD, 0);
        gap(2);
        check("hold_byte_count", byte_count, MIN_PAYLOAD);
        check("hold_err_none", err_code, ERR_NONE);

        // Runt.
        frame_closed(3, 20, 0);
        gap(1);

        // Header timeout; code is held through the gap that follows.
        frame_hdr_timeout();
        gap(2);
        check("hold_err_timeout", err_code, ERR_HDR_TIMEOUT);
        check("hold_state_idle", state_o, ST_IDLE);

        frame_oversize(5);
        gap(1);
        frame_hdr_abort(4);
        gap(1);
        frame_tail_oversize(2);
        gap(1);

        // Asynchronous reset during payload beat 30.
        send_header(HDR_MAX, 1'b1);
        send_payload(29, 1'b0);
        @(negedge clock);
        control = 1'b1;
        data    = rnd_data();
        #1;
        check("mid_frame_byte_count", byte_count, 29);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(negedge clock);
        control = 1'b0;
        reset   = 1'b1;
        frame_closed(HDR_MAX, MIN_PAYLOAD, 0);

        // Back-to-back frames, no gap cycles.
        frame_closed(1, 50, 2);
        frame_closed(2, MIN_PAYLOAD - 1, 0);
        frame_closed(HDR_MAX, MIN_PAYLOAD, 1);
        gap(1);

        // Random mix.
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1:    frame_closed($urandom_range(1, HDR_MAX), $urandom_range(1, 70), $urandom_range(0, 5));
                2:       frame_hdr_abort($urandom_range(1, HDR_MAX - 1));
                3:       frame_pay_abort($urandom_range(1, HDR_MAX), $urandom_range(0, 60));
                4:       frame_hdr_timeout();
                default: frame_closed($urandom_range(1, HDR_MAX), $urandom_range(40, 60), 0);
            endcase
            gap($urandom_range(0, 3));
        end

        gap(4);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
